// File: rtl/xt_hb_rr_bridge.sv
// rtl/xt_hb_rr_bridge.sv - multi-master to multi-domain bridge with independent round-robin read/write channels
// Optional per-transaction timeout is compiled in with XT_HB_TIMEOUT_EN.

module xt_hb_rr_chan #(
  parameter int MASTER_NUM        = 2,
  parameter int DOMAIN_NUM        = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int MAPPED_ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPLIT [DOMAIN_NUM] = '{32'h1000, 32'h2000},
  parameter int TIMEOUT_CYCLES    = 16,
  localparam int IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1,
  localparam int DW = (DOMAIN_NUM > 1) ? $clog2(DOMAIN_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst_sync_n,
  input  logic [MASTER_NUM-1:0]          req_i,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0] addr_i,
  input  logic [DOMAIN_NUM-1:0]          finish_i,
  output logic [MASTER_NUM-1:0]          grant_o,
  output logic [MASTER_NUM-1:0]          done_o,
  output logic                           err_o,
  output logic [DOMAIN_NUM-1:0]          sel_o,
  output logic [MAPPED_ADDR_WIDTH-1:0]   maddr_o,
  output logic                           busy_o,
  output logic [IW-1:0]                  idx_o,
  output logic [DW-1:0]                  dom_o,
  output logic                           data_ok_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [MASTER_NUM-1:0]   grant_q, grant_d;
  logic [IW-1:0]           idx_q, idx_d, ptr_q, ptr_d, pick;
  logic [ADDR_WIDTH-1:0]   addr, base, lo;
  logic [DW-1:0]           didx;
  logic                    hit, busy, req_g, active, unm, fin, tmo, done, found;

  always_comb begin
    addr = addr_i[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
    hit  = 1'b0;
    didx = '0;
    base = '0;
    lo   = '0;
    // Splits are ascending, so the first bound above addr is the owning domain.
    for (int i = 0; i < DOMAIN_NUM; i++) begin
      if (!hit && addr < ADDR_SPLIT[i]) begin
        hit  = 1'b1;
        didx = DW'(i);
        base = lo;
      end
      lo = ADDR_SPLIT[i];
    end
  end

  assign busy   = (state_q == BUSY);
  assign req_g  = req_i[idx_q];
  assign active = busy && req_g;
  assign unm    = active && !hit;
  assign fin    = active && hit && finish_i[didx];

`ifdef XT_HB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo   = active && hit && !finish_i[didx] && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = (active && !done) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!rst_sync_n) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign done = unm || fin || tmo;

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < DOMAIN_NUM; i++) sel_o[i] = active && hit && (didx == DW'(i));
  end

  assign grant_o   = grant_q;
  assign done_o    = done ? grant_q : '0;
  assign err_o     = unm || tmo;
  assign maddr_o   = (busy && hit) ? MAPPED_ADDR_WIDTH'(addr - base) : '0;
  assign busy_o    = busy;
  assign idx_o     = idx_q;
  assign dom_o     = didx;
  assign data_ok_o = fin;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    pick    = '0;
    for (int k = 0; k < MASTER_NUM; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % MASTER_NUM]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr_q) + k) % MASTER_NUM);
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          idx_d         = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      BUSY: begin
        // A dropped request aborts the transaction but still rotates priority.
        if (done || !req_g) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (idx_q == IW'(MASTER_NUM - 1)) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

module xt_hb_rr_bridge #(
  parameter int MASTER_NUM        = 2,
  parameter int DOMAIN_NUM        = 2,
  parameter int ADDR_WIDTH        = 32,
  parameter int MAPPED_ADDR_WIDTH = 24,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPLIT [DOMAIN_NUM] = '{32'h1000, 32'h2000},
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                             clk,
  input  logic                             rst_sync_n,
  input  logic [MASTER_NUM-1:0]            m_read,
  input  logic [MASTER_NUM-1:0]            m_write,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_raddr,
  input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_waddr,
  input  logic [MASTER_NUM*32-1:0]         m_wdata,
  input  logic [MASTER_NUM*2-1:0]          m_write_width,
  input  logic [DOMAIN_NUM*32-1:0]         domain_rdata,
  input  logic [DOMAIN_NUM-1:0]            read_finish,
  input  logic [DOMAIN_NUM-1:0]            write_finish,
  output logic [MASTER_NUM-1:0]            read_grant,
  output logic [MASTER_NUM-1:0]            write_grant,
  output logic [MASTER_NUM-1:0]            read_done,
  output logic [MASTER_NUM-1:0]            write_done,
  output logic                             read_err,
  output logic                             write_err,
  output logic [MASTER_NUM-1:0]            stall_req,
  output logic [31:0]                      hb_rdata,
  output logic [MAPPED_ADDR_WIDTH-1:0]     bus_raddr,
  output logic [MAPPED_ADDR_WIDTH-1:0]     bus_waddr,
  output logic [31:0]                      bus_wdata,
  output logic [1:0]                       bus_write_width,
  output logic [DOMAIN_NUM-1:0]            domain_ren,
  output logic [DOMAIN_NUM-1:0]            domain_wen
);

  localparam int IW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int DW = (DOMAIN_NUM > 1) ? $clog2(DOMAIN_NUM) : 1;

  logic          rd_busy, wr_busy, rd_ok, wr_ok;
  logic [IW-1:0] rd_idx, wr_idx;
  logic [DW-1:0] rd_dom, wr_dom;

  xt_hb_rr_chan #(
    .MASTER_NUM(MASTER_NUM), .DOMAIN_NUM(DOMAIN_NUM), .ADDR_WIDTH(ADDR_WIDTH),
    .MAPPED_ADDR_WIDTH(MAPPED_ADDR_WIDTH), .ADDR_SPLIT(ADDR_SPLIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd (
    .clk(clk), .rst_sync_n(rst_sync_n), .req_i(m_read), .addr_i(m_raddr), .finish_i(read_finish),
    .grant_o(read_grant), .done_o(read_done), .err_o(read_err), .sel_o(domain_ren),
    .maddr_o(bus_raddr), .busy_o(rd_busy), .idx_o(rd_idx), .dom_o(rd_dom), .data_ok_o(rd_ok)
  );

  xt_hb_rr_chan #(
    .MASTER_NUM(MASTER_NUM), .DOMAIN_NUM(DOMAIN_NUM), .ADDR_WIDTH(ADDR_WIDTH),
    .MAPPED_ADDR_WIDTH(MAPPED_ADDR_WIDTH), .ADDR_SPLIT(ADDR_SPLIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wr (
    .clk(clk), .rst_sync_n(rst_sync_n), .req_i(m_write), .addr_i(m_waddr), .finish_i(write_finish),
    .grant_o(write_grant), .done_o(write_done), .err_o(write_err), .sel_o(domain_wen),
    .maddr_o(bus_waddr), .busy_o(wr_busy), .idx_o(wr_idx), .dom_o(wr_dom), .data_ok_o(wr_ok)
  );

  assign hb_rdata        = rd_ok ? domain_rdata[rd_dom*32 +: 32] : 32'h0;
  assign bus_wdata       = wr_busy ? m_wdata[wr_idx*32 +: 32] : 32'h0;
  assign bus_write_width = wr_busy ? m_write_width[wr_idx*2 +: 2] : 2'b00;
  assign stall_req       = (m_read & ~read_done) | (m_write & ~write_done);

  logic unused_ok;
  assign unused_ok = rd_busy ^ wr_ok;

endmodule
